// File: rtl/alu_issue_stage_pkg.sv
// Shared ALU control/op encodings and the issue-entry record used by the issue stage.
// Also consumed by the control unit that reuses the control decoder.
package alu_issue_stage_pkg;

  localparam int DATA_W = 32;

  localparam logic [3:0] CTL_AND = 4'b0000;
  localparam logic [3:0] CTL_OR  = 4'b0001;
  localparam logic [3:0] CTL_ADD = 4'b0010;
  localparam logic [3:0] CTL_SUB = 4'b0110;

  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_SUM = 2'b10;

  typedef struct packed {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic              binvert;
    logic              carryin;
    logic [1:0]        op;
  } issue_entry_t;

endpackage

// File: rtl/alu_issue_stage_if.sv
// Upstream instruction handshake plus downstream ALU-facing handshake of the issue stage.
// slave = the issue stage itself, master = whoever drives it.
interface alu_issue_stage_if #(
  parameter int W = 32
) ();
  logic         flush;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic [3:0]   in_ctl;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] in1;
  logic [W-1:0] in2;
  logic         binvert;
  logic         carryin;
  logic [1:0]   op;
  logic         err_illegal;
  logic [1:0]   count;

  modport slave (
    input  flush, in_valid, in_a, in_b, in_ctl, out_ready,
    output in_ready, out_valid, in1, in2, binvert, carryin, op, err_illegal, count
  );

  modport master (
    output flush, in_valid, in_a, in_b, in_ctl, out_ready,
    input  in_ready, out_valid, in1, in2, binvert, carryin, op, err_illegal, count
  );
endinterface

// File: rtl/alu_issue_stage_alu_ctl_decode.sv
// Combinational 4-bit ALU control code -> {binvert, carryin, op, illegal}.
// Zero latency; no state, so no backpressure of its own.
module alu_ctl_decode
  import alu_issue_stage_pkg::*;
(
  input  logic [3:0] ctl,
  output logic       binvert,
  output logic       carryin,
  output logic [1:0] op,
  output logic       illegal
);

  always_comb begin
    binvert = 1'b0;
    carryin = 1'b0;
    op      = OP_AND;
    illegal = 1'b0;
    case (ctl)
      CTL_AND: op = OP_AND;
      CTL_OR:  op = OP_OR;
      CTL_ADD: op = OP_SUM;
      CTL_SUB: begin
        op      = OP_SUM;
        binvert = 1'b1;
        carryin = 1'b1;
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_issue_stage.sv
// Issue stage: decodes ALU control at push into a 2-entry registered FIFO; head visible the cycle after push.
// in_ready depends only on registered occupancy; head holds steady while out_ready is low.
module alu_issue_stage
  import alu_issue_stage_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int W     = DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  alu_issue_stage_if.slave  bus
);

  localparam logic [1:0] FULL_CNT = 2'(DEPTH);

  issue_entry_t mem_q [2];
  issue_entry_t mem_d [2];
  issue_entry_t last_q, last_d;
  issue_entry_t head, new_entry;
  logic         wr_ptr_q, wr_ptr_d;
  logic         rd_ptr_q, rd_ptr_d;
  logic [1:0]   count_q, count_d;
  logic         err_q, err_d;
  logic         dec_binvert, dec_carryin, dec_illegal;
  logic [1:0]   dec_op;
  logic         push, store, pop;

  alu_ctl_decode u_decode (
    .ctl     (bus.in_ctl),
    .binvert (dec_binvert),
    .carryin (dec_carryin),
    .op      (dec_op),
    .illegal (dec_illegal)
  );

  assign bus.in_ready    = (count_q != FULL_CNT);
  assign bus.out_valid   = (count_q != 2'd0);
  assign bus.count       = count_q;
  assign bus.err_illegal = err_q;
  assign bus.in1         = head.a[W-1:0];
  assign bus.in2         = head.b[W-1:0];
  assign bus.binvert     = head.binvert;
  assign bus.carryin     = head.carryin;
  assign bus.op          = head.op;

  always_comb begin
    // When empty, the outputs keep showing whatever was last presented.
    head      = (count_q != 2'd0) ? mem_q[rd_ptr_q] : last_q;
    new_entry = '{a: bus.in_a, b: bus.in_b, binvert: dec_binvert,
                  carryin: dec_carryin, op: dec_op};
    push      = bus.in_valid && bus.in_ready;
    store     = push && !dec_illegal && !bus.flush;
    pop       = (count_q != 2'd0) && bus.out_ready;

    mem_d     = mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    last_d    = head;
    err_d     = push && dec_illegal && !bus.flush;

    if (bus.flush) begin
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
      count_d  = 2'd0;
    end else begin
      if (store) begin
        mem_d[wr_ptr_q] = new_entry;
        wr_ptr_d        = ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_d = ~rd_ptr_q;
      end
      count_d = count_q + {1'b0, store} - {1'b0, pop};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        mem_q[i] <= '0;
      end
      last_q   <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
      err_q    <= 1'b0;
    end else begin
      mem_q    <= mem_d;
      last_q   <= last_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      err_q    <= err_d;
    end
  end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: directed vector table, hand sequences (stream + mid-stream reset),
// then random traffic checked against a queue-based reference model.
module tb_alu_issue_stage;
  import alu_issue_stage_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  alu_issue_stage_if #(.W(32)) bus ();

  alu_issue_stage #(.DEPTH(2), .W(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int n_checks = 0;
  int n_errors = 0;

  issue_entry_t mq[$];
  issue_entry_t m_last;
  logic         m_err;

  typedef struct {
    logic        fl, iv;
    logic [31:0] a, b;
    logic [3:0]  ctl;
    logic        ordy;
    logic [1:0]  cnt;
    logic        ov, ir, err;
    logic [31:0] in1, in2;
    logic        bi, ci;
    logic [1:0]  op;
  } vec_t;

  vec_t vt[17];

  function automatic logic [79:0] pack(logic ov, logic ir, logic [1:0] cnt, logic err,
                                       logic [31:0] a, logic [31:0] b, logic bi, logic ci,
                                       logic [1:0] op);
    return {7'd0, ov, ir, cnt, err, a, b, bi, ci, op};
  endfunction

  function automatic logic [79:0] dut_obs();
    return pack(bus.out_valid, bus.in_ready, bus.count, bus.err_illegal,
                bus.in1, bus.in2, bus.binvert, bus.carryin, bus.op);
  endfunction

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (ov,ir,cnt,err,in1,in2,bi,ci,op)", name, act, exp);
    end
  endtask

  // Reference model: a plain queue of decoded entries, following the ALU control table directly.
  function automatic logic model_decode(input logic [31:0] a, input logic [31:0] b,
                                        input logic [3:0] ctl, output issue_entry_t e);
    e = '{a: a, b: b, binvert: 1'b0, carryin: 1'b0, op: 2'b00};
    case (ctl)
      4'b0000: e.op = 2'b00;
      4'b0001: e.op = 2'b01;
      4'b0010: e.op = 2'b10;
      4'b0110: begin e.op = 2'b10; e.binvert = 1'b1; e.carryin = 1'b1; end
      default: return 1'b0;
    endcase
    return 1'b1;
  endfunction

  function automatic logic [79:0] model_exp();
    issue_entry_t h;
    h = (mq.size() != 0) ? mq[0] : m_last;
    return pack(mq.size() != 0, mq.size() != 2, 2'(mq.size()), m_err,
                h.a, h.b, h.binvert, h.carryin, h.op);
  endfunction

  task automatic model_edge(input logic fl, input logic iv, input logic [31:0] a,
                            input logic [31:0] b, input logic [3:0] ctl, input logic ordy);
    issue_entry_t e;
    logic legal, psh, pp;
    legal  = model_decode(a, b, ctl, e);
    psh    = iv && (mq.size() < 2);
    pp     = ordy && (mq.size() > 0);
    m_last = (mq.size() != 0) ? mq[0] : m_last;
    if (fl) begin
      mq.delete();
      m_err = 1'b0;
    end else begin
      if (pp) void'(mq.pop_front());
      if (psh && legal) mq.push_back(e);
      m_err = psh && !legal;
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_last = '0;
    m_err  = 1'b0;
  endtask

  // Called at a falling edge: drive, compare against the model, advance one clock.
  task automatic step(input logic fl, input logic iv, input logic [31:0] a, input logic [31:0] b,
                      input logic [3:0] ctl, input logic ordy);
    bus.flush     = fl;
    bus.in_valid  = iv;
    bus.in_a      = a;
    bus.in_b      = b;
    bus.in_ctl    = ctl;
    bus.out_ready = ordy;
    check("model", dut_obs(), model_exp());
    model_edge(fl, iv, a, b, ctl, ordy);
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic vec_t mkv(logic fl, logic iv, logic [31:0] a, logic [31:0] b, logic [3:0] ctl,
                               logic ordy, logic [1:0] cnt, logic ov, logic ir, logic err,
                               logic [31:0] in1, logic [31:0] in2, logic bi, logic ci,
                               logic [1:0] op);
    vec_t v;
    v.fl = fl; v.iv = iv; v.a = a; v.b = b; v.ctl = ctl; v.ordy = ordy;
    v.cnt = cnt; v.ov = ov; v.ir = ir; v.err = err;
    v.in1 = in1; v.in2 = in2; v.bi = bi; v.ci = ci; v.op = op;
    return v;
  endfunction

  initial begin
    logic        r_iv, r_fl, r_ord, held;
    logic [31:0] r_a, r_b;
    logic [3:0]  r_ctl;

    //          fl iv a             b             ctl      ordy cnt ov ir er in1           in2           bi ci op
    vt[0]  = mkv(0, 1, 32'd5,        32'd3,        4'b0110, 1, 1, 1, 1, 0, 32'd5,        32'd3,        1, 1, 2'b10);
    vt[1]  = mkv(0, 0, 32'd0,        32'd0,        4'b0000, 1, 0, 0, 1, 0, 32'd5,        32'd3,        1, 1, 2'b10);
    vt[2]  = mkv(0, 1, 32'd1,        32'd2,        4'b0010, 0, 1, 1, 1, 0, 32'd1,        32'd2,        0, 0, 2'b10);
    vt[3]  = mkv(0, 1, 32'hF0,       32'h0F,       4'b0001, 0, 2, 1, 0, 0, 32'd1,        32'd2,        0, 0, 2'b10);
    vt[4]  = mkv(0, 0, 32'd0,        32'd0,        4'b0000, 0, 2, 1, 0, 0, 32'd1,        32'd2,        0, 0, 2'b10);
    vt[5]  = mkv(0, 0, 32'd0,        32'd0,        4'b0000, 1, 1, 1, 1, 0, 32'hF0,       32'h0F,       0, 0, 2'b01);
    vt[6]  = mkv(0, 1, 32'd7,        32'd7,        4'b1100, 0, 1, 1, 1, 1, 32'hF0,       32'h0F,       0, 0, 2'b01);
    vt[7]  = mkv(0, 0, 32'd0,        32'd0,        4'b0000, 0, 1, 1, 1, 0, 32'hF0,       32'h0F,       0, 0, 2'b01);
    vt[8]  = mkv(0, 1, 32'hFFFF0000, 32'h00FFFF00, 4'b0000, 1, 1, 1, 1, 0, 32'hFFFF0000, 32'h00FFFF00, 0, 0, 2'b00);
    vt[9]  = mkv(0, 1, 32'd10,       32'd20,       4'b0010, 0, 2, 1, 0, 0, 32'hFFFF0000, 32'h00FFFF00, 0, 0, 2'b00);
    vt[10] = mkv(1, 1, 32'd10,       32'd20,       4'b0010, 0, 0, 0, 1, 0, 32'hFFFF0000, 32'h00FFFF00, 0, 0, 2'b00);
    vt[11] = mkv(1, 1, 32'h99,       32'd1,        4'b0110, 0, 0, 0, 1, 0, 32'hFFFF0000, 32'h00FFFF00, 0, 0, 2'b00);
    vt[12] = mkv(1, 1, 32'h55,       32'h66,       4'b1111, 0, 0, 0, 1, 0, 32'hFFFF0000, 32'h00FFFF00, 0, 0, 2'b00);
    vt[13] = mkv(0, 0, 32'd0,        32'd0,        4'b0000, 0, 0, 0, 1, 0, 32'hFFFF0000, 32'h00FFFF00, 0, 0, 2'b00);
    vt[14] = mkv(0, 1, 32'd3,        32'd4,        4'b0001, 0, 1, 1, 1, 0, 32'd3,        32'd4,        0, 0, 2'b01);
    vt[15] = mkv(0, 1, 32'd8,        32'd9,        4'b0111, 1, 0, 0, 1, 1, 32'd3,        32'd4,        0, 0, 2'b01);
    vt[16] = mkv(0, 0, 32'd0,        32'd0,        4'b0000, 0, 0, 0, 1, 0, 32'd3,        32'd4,        0, 0, 2'b01);

    rst_n         = 1'b0;
    bus.flush     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_ctl    = '0;
    bus.out_ready = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check("reset", dut_obs(), pack(0, 1, 2'd0, 0, 32'd0, 32'd0, 0, 0, 2'b00));
    rst_n = 1'b1;

    for (int i = 0; i < 17; i++) begin
      step(vt[i].fl, vt[i].iv, vt[i].a, vt[i].b, vt[i].ctl, vt[i].ordy);
      check($sformatf("vec%0d", i), dut_obs(),
            pack(vt[i].ov, vt[i].ir, vt[i].cnt, vt[i].err,
                 vt[i].in1, vt[i].in2, vt[i].bi, vt[i].ci, vt[i].op));
    end

    // Back-to-back ADD/SUB stream, with an asynchronous reset landing mid-stream.
    for (int i = 0; i < 8; i++) begin
      logic [31:0] sa, sb;
      logic        sub;
      sa  = 32'(i * 3 + 1);
      sb  = 32'(i + 100);
      sub = (i % 2) == 1;
      step(0, 1, sa, sb, sub ? 4'b0110 : 4'b0010, 1);
      check($sformatf("stream%0d", i), dut_obs(), pack(1, 1, 2'd1, 0, sa, sb, sub, sub, 2'b10));
      if (i == 5) begin
        #2 rst_n = 1'b0;
        #1 check("midreset", dut_obs(), pack(0, 1, 2'd0, 0, 32'd0, 32'd0, 0, 0, 2'b00));
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
      end
    end
    step(0, 0, 32'd0, 32'd0, 4'b0000, 1);
    check("stream_drain", dut_obs(), pack(0, 1, 2'd0, 0, 32'd22, 32'd107, 1, 1, 2'b10));

    held  = 1'b0;
    r_iv  = 1'b0;
    r_a   = '0;
    r_b   = '0;
    r_ctl = '0;
    for (int c = 0; c < 600; c++) begin
      if (!held) begin
        r_iv = ($urandom_range(0, 3) != 0);
        r_a  = $urandom;
        r_b  = $urandom;
        case ($urandom_range(0, 5))
          0: r_ctl = 4'b0000;
          1: r_ctl = 4'b0001;
          2: r_ctl = 4'b0010;
          3: r_ctl = 4'b0110;
          default: r_ctl = 4'($urandom_range(0, 15));
        endcase
      end
      r_fl  = ($urandom_range(0, 23) == 0);
      r_ord = ($urandom_range(0, 2) != 0);
      held  = r_iv && (mq.size() == 2);
      step(r_fl, r_iv, r_a, r_b, r_ctl, r_ord);
    end
    check("final", dut_obs(), model_exp());

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- Operand/control issue stage directly upstream of the 32-bit ALU datapath.
- Accepts decoded instructions via valid/ready, translates the 4-bit ALU control code into the ALU's binvert/carryin/op controls, and buffers up to 2 entries in a registered skid FIFO.
- Presents the head entry to the ALU with valid/ready.
- Rejects control codes the ALU cannot execute and reports them with an error pulse.

Parameters:
- DEPTH, 2, FIFO entries; only 2 is supported.
- W, 32, operand width; must match the ALU.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous clear of all buffered entries.
- in_valid  in  1  upstream entry valid.
- in_ready  out  1  stage can accept an entry.
- in_a  in  W  operand A (rs).
- in_b  in  W  operand B (rt/imm).
- in_ctl  in  4  ALU control code.
- out_valid  out  1  head entry valid toward the ALU.
- out_ready  in  1  ALU side consumes the head entry.
- in1  out  W  ALU operand 1.
- in2  out  W  ALU operand 2.
- binvert  out  1  ALU B-invert select.
- carryin  out  1  ALU carry-in.
- op  out  2  ALU result select: 00=AND, 01=OR, 10=SUM.
- err_illegal  out  1  one-cycle pulse for an accepted illegal code.
- count  out  2  occupancy, 0..2.

Behaviour:
- Reset (asynchronous, rst_n=0): count=0, out_valid=0, err_illegal=0, in1=in2=0, binvert=carryin=0, op=00. in_ready=1 once reset is released.
- Handshake rules:
  - Push when in_valid && in_ready.
  - Pop when out_valid && out_ready.
  - Upstream must hold in_a/in_b/in_ctl stable while in_valid && !in_ready.
- Decode (registered at push):
  - 0000 AND → op=00, binvert=0, carryin=0.
  - 0001 OR → op=01, binvert=0, carryin=0.
  - 0010 ADD → op=10, binvert=0, carryin=0.
  - 0110 SUB → op=10, binvert=1, carryin=1.
  - Any other code is illegal: the handshake completes, nothing is stored, and err_illegal=1 on the following cycle only.
- Storage: 2-entry circular buffer with 1-bit rd/wr pointers that wrap 1→0. Each entry holds {a, b, binvert, carryin, op}.
- in_ready = (count != 2). It is a function of registered count only; no combinational in→out path.
- out_valid = (count != 0). in1/in2/binvert/carryin/op always reflect the head entry. When empty they hold their last values (reset values if nothing was ever pushed).
- Latency: an entry pushed in cycle N is visible at the outputs with out_valid=1 in cycle N+1.
- Throughput: 1 entry/cycle sustained when out_ready=1.
- Simultaneous push+pop:
  - count=1: count stays 1, head advances to the new entry.
  - count=0: no pop is possible; push only.
  - count=2: push is blocked by in_ready=0; pop only.
- Illegal push with simultaneous pop: count decrements; the illegal code is not stored.
- Backpressure (out_ready=0 with out_valid=1): head entry and its outputs hold stable.
- flush=1:
  - Next edge: count=0, pointers=0, out_valid=0.
  - A same-cycle push is discarded. err_illegal is also suppressed for that push.
  - in_ready is still driven by count.
- Reset mid-operation: all state cleared immediately; in-flight entries are lost.

Decomposition:
- Shared package:
  - ALU control code constants (CTL_AND=4'b0000, CTL_OR=4'b0001, CTL_ADD=4'b0010, CTL_SUB=4'b0110).
  - ALU op select constants (OP_AND=2'b00, OP_OR=2'b01, OP_SUM=2'b10).
  - Issue-entry struct typedef {a, b, binvert, carryin, op}.
- One sub-module: alu_ctl_decode. Combinational in_ctl → {binvert, carryin, op, illegal}; reused later by the control unit.

Test Plan:
- Reset then single push of a=5, b=3, ctl=0110 with out_ready=1 → next cycle out_valid=1, in1=5, in2=3, binvert=1, carryin=1, op=10; count returns to 0 after the pop.
- out_ready=0, push ADD(1,2) then OR(0xF0,0x0F) → count=2, in_ready=0, head stays ADD. Release out_ready → ADD, then OR (op=01) are popped in order.
- Push ctl=1100 → in_ready stays 1, count unchanged, err_illegal=1 for exactly one cycle, out_valid unaffected.
- count=1 with simultaneous push AND(0xFFFF0000,0x00FFFF00) and pop → count stays 1; head becomes the AND entry with op=00, binvert=0.
- count=2, assert flush with in_valid=1 → next cycle count=0, out_valid=0, in_ready=1; the pushed entry never appears at the outputs.
- Stream of 8 alternating ADD/SUB pushes with out_ready=1 → one pop per cycle, pointers wrap correctly, outputs match inputs in order with 1-cycle latency. Assert rst_n=0 mid-stream → outputs return to reset values immediately.
